// File: rtl/timer_bus_sequencer.sv
`timescale 1ns/1ps
// Avalon-MM master sequencing an interval-timer slave:
// start/stop/snapshot commands plus hardware IRQ servicing and tick counting.
module timer_bus_sequencer #(
  parameter int          TICK_W         = 16,
  parameter int          AUTO_START     = 0,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_period,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              busy,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_ST, WR_CTL,
    STOP_CTL, STOP_ST,
    SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP,
    IRQ_CLR
  } state_t;

  localparam logic [1:0] OP_CONT = 2'd0;
  localparam logic [1:0] OP_ONE  = 2'd1;
  localparam logic [1:0] OP_STOP = 2'd2;
  localparam logic [1:0] OP_SNAP = 2'd3;

  localparam state_t RST_STATE =
    (AUTO_START != 0) ? WR_PL : IDLE;
  localparam logic [31:0] RST_PERIOD =
    (DEFAULT_PERIOD == 32'd0) ? 32'd1 : DEFAULT_PERIOD;

  state_t      state, state_n;
  logic [1:0]  op_q;
  logic [31:0] per_q;
  logic [15:0] snap_lo;
  logic        accept;
  logic        is_start;

  assign cmd_ready = (state == IDLE) && !tmr_irq && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign is_start  = (cmd_op == OP_CONT) || (cmd_op == OP_ONE);
  assign busy      = (state != IDLE);
  assign tick      = (state == IRQ_CLR) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RST_STATE;
      op_q       <= OP_CONT;
      per_q      <= RST_PERIOD;
      snap_lo    <= 16'h0;
      snap_valid <= 1'b0;
      snap_value <= 32'h0;
      tick_count <= '0;
    end else begin
      state      <= state_n;
      snap_valid <= (state == SNAP_CAP);
      if (accept) begin
        op_q  <= cmd_op;
        per_q <= (cmd_period == 32'd0) ? 32'd1 : cmd_period;
        if (is_start)
          tick_count <= '0;
      end
      if (state == IDLE && tmr_irq)
        tick_count <= tick_count + TICK_W'(1);
      if (state == SNAP_RH)
        snap_lo <= tmr_readdata;
      if (state == SNAP_CAP)
        snap_value <= {tmr_readdata, snap_lo};
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (tmr_irq)
          state_n = IRQ_CLR;
        else if (cmd_valid) begin
          case (cmd_op)
            OP_STOP: state_n = STOP_CTL;
            OP_SNAP: state_n = SNAP_W;
            default: state_n = WR_PL;
          endcase
        end
      end
      WR_PL:    state_n = WR_PH;
      WR_PH:    state_n = WR_ST;
      WR_ST:    state_n = WR_CTL;
      WR_CTL:   state_n = IDLE;
      STOP_CTL: state_n = STOP_ST;
      STOP_ST:  state_n = IDLE;
      SNAP_W:   state_n = SNAP_RL;
      SNAP_RL:  state_n = SNAP_RH;
      SNAP_RH:  state_n = SNAP_CAP;
      SNAP_CAP: state_n = IDLE;
      IRQ_CLR:  state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Bus is a decode of the state register; held quiet while
  // reset is asserted even when the reset state is WR_PL.
  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'h0;
    if (!reset) begin
      unique case (state)
        WR_PL: begin
          tmr_chipselect = 1'b1;
          tmr_write_n    = 1'b0;
          tmr_address    = 3'd2;
          tmr_writedata  = per_q[15:0];
        end
        WR_PH: begin
          tmr_chipselect = 1'b1;
          tmr_write_n    = 1'b0;
          tmr_address    = 3'd3;
          tmr_writedata  = per_q[31:16];
        end
        WR_ST, STOP_ST, IRQ_CLR: begin
          tmr_chipselect = 1'b1;
          tmr_write_n    = 1'b0;
        end
        WR_CTL: begin
          tmr_chipselect = 1'b1;
          tmr_write_n    = 1'b0;
          tmr_address    = 3'd1;
          tmr_writedata  = (op_q == OP_ONE) ? 16'h0005 : 16'h0007;
        end
        STOP_CTL: begin
          tmr_chipselect = 1'b1;
          tmr_write_n    = 1'b0;
          tmr_address    = 3'd1;
          tmr_writedata  = 16'h0008;
        end
        SNAP_W: begin
          tmr_chipselect = 1'b1;
          tmr_write_n    = 1'b0;
          tmr_address    = 3'd4;
        end
        SNAP_RL: begin
          tmr_chipselect = 1'b1;
          tmr_address    = 3'd4;
        end
        SNAP_RH: begin
          tmr_chipselect = 1'b1;
          tmr_address    = 3'd5;
        end
        default: begin
          tmr_chipselect = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_bus_sequencer.sv
`timescale 1ns/1ps
// Bench for timer_bus_sequencer: slave model, bus log and
// directed/random command sequences against a transaction model.
module tb_timer_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cv[2], cr[2], sv[2], tk[2], bsy[2];
  logic        cs[2], wn[2], irq[2], req[2];
  logic [1:0]  cop[2];
  logic [31:0] cper[2], sval[2], snap_src[2], snapreg[2];
  logic [2:0]  addr[2];
  logic [15:0] wd[2], rd[2];
  logic [15:0] tcnt0;
  logic [3:0]  tcnt1;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int bsy_cnt[2], tk_cnt[2], sv_cnt[2], sv_cyc[2];
  int viol = 0;
  int ticks_a = 0;

  typedef struct {
    int         c;
    logic [19:0] e;
  } acc_t;
  acc_t        lg0[$], lg1[$];
  logic [19:0] exp_q[$];

  timer_bus_sequencer u_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cv[0]), .cmd_ready(cr[0]),
    .cmd_op(cop[0]), .cmd_period(cper[0]),
    .snap_valid(sv[0]), .snap_value(sval[0]),
    .tick(tk[0]), .tick_count(tcnt0), .busy(bsy[0]),
    .tmr_address(addr[0]), .tmr_chipselect(cs[0]),
    .tmr_write_n(wn[0]), .tmr_writedata(wd[0]),
    .tmr_readdata(rd[0]), .tmr_irq(irq[0])
  );

  timer_bus_sequencer #(
    .TICK_W(4), .AUTO_START(1), .DEFAULT_PERIOD(32'd50000)
  ) u_b (
    .clk(clk), .reset(reset),
    .cmd_valid(cv[1]), .cmd_ready(cr[1]),
    .cmd_op(cop[1]), .cmd_period(cper[1]),
    .snap_valid(sv[1]), .snap_value(sval[1]),
    .tick(tk[1]), .tick_count(tcnt1), .busy(bsy[1]),
    .tmr_address(addr[1]), .tmr_chipselect(cs[1]),
    .tmr_write_n(wn[1]), .tmr_writedata(wd[1]),
    .tmr_readdata(rd[1]), .tmr_irq(irq[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave: clear wins over a new timeout; registered reads.
  always_ff @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        irq[g]     <= 1'b0;
        rd[g]      <= 16'h0;
        snapreg[g] <= 32'h0;
      end else begin
        if (cs[g] && !wn[g] && addr[g] == 3'd0)
          irq[g] <= 1'b0;
        else if (req[g])
          irq[g] <= 1'b1;
        if (cs[g] && !wn[g] && addr[g] == 3'd4)
          snapreg[g] <= snap_src[g];
        if (cs[g] && wn[g] && addr[g] == 3'd4)
          rd[g] <= snapreg[g][15:0];
        else if (cs[g] && wn[g] && addr[g] == 3'd5)
          rd[g] <= snapreg[g][31:16];
        else
          rd[g] <= 16'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (cs[0] === 1'b1) lg0.push_back('{c: cyc, e: {addr[0], wn[0], wd[0]}});
    if (cs[1] === 1'b1) lg1.push_back('{c: cyc, e: {addr[1], wn[1], wd[1]}});
    for (int g = 0; g < 2; g++) begin
      if (bsy[g] === 1'b1) bsy_cnt[g]++;
      if (tk[g] === 1'b1) tk_cnt[g]++;
      if (sv[g] === 1'b1) begin
        sv_cnt[g]++;
        sv_cyc[g] = cyc;
      end
      if (irq[g] === 1'b1 && cr[g] === 1'b1) viol++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] wr(input logic [2:0] a,
                                     input logic [15:0] d);
    return {a, 1'b0, d};
  endfunction

  function automatic logic [19:0] rdx(input logic [2:0] a);
    return {a, 1'b1, 16'h0};
  endfunction

  // Expected bus transactions for a START command.
  task automatic model_start(input logic [1:0] op, input logic [31:0] per);
    logic [31:0] p;
    p = (per == 32'd0) ? 32'd1 : per;
    exp_q.push_back(wr(3'd2, p[15:0]));
    exp_q.push_back(wr(3'd3, p[31:16]));
    exp_q.push_back(wr(3'd0, 16'h0));
    exp_q.push_back(wr(3'd1, (op == 2'd1) ? 16'h0005 : 16'h0007));
  endtask

  task automatic check_log(input string tag, input int w, input int first);
    acc_t got[$];
    if (w == 0) begin got = lg0; lg0.delete(); end
    else begin got = lg1; lg1.delete(); end
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got.size()) begin
        chk($sformatf("%s_acc%0d", tag, i), 32'(got[i].e), 32'(exp_q[i]));
        if (first >= 0)
          chk($sformatf("%s_cyc%0d", tag, i), 32'(got[i].c), 32'(first + i));
      end
    end
    exp_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept(input int w, output int acc);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cr[w] === 1'b1) break;
    end
    chk("accept", 32'(cr[w]), 32'd1);
    acc = cyc;
    step();
    cv[w] = 1'b0;
  endtask

  task automatic send(input int w, input logic [1:0] op,
                      input logic [31:0] per, output int acc);
    step();
    cv[w] = 1'b1;
    cop[w] = op;
    cper[w] = per;
    wait_accept(w, acc);
  endtask

  task automatic pulse(input int w);
    step();
    req[w] = 1'b1;
    step();
    req[w] = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    int acc, r;
    logic [1:0]  op;
    logic [31:0] per;
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      cv[g] = 1'b0; cop[g] = 2'd0; cper[g] = 32'h0;
      req[g] = 1'b0; snap_src[g] = 32'h0;
      bsy_cnt[g] = 0; tk_cnt[g] = 0; sv_cnt[g] = 0; sv_cyc[g] = -1;
    end

    repeat (3) step();
    @(negedge clk);
    chk("rst_ready", 32'(cr[0]), 32'd0);
    chk("rst_cs", 32'(cs[0]), 32'd0);
    chk("rst_wn", 32'(wn[0]), 32'd1);
    chk("rst_addr", 32'(addr[0]), 32'd0);
    chk("rst_wd", 32'(wd[0]), 32'd0);
    chk("rst_sv", 32'(sv[0]), 32'd0);
    chk("rst_sval", sval[0], 32'd0);
    chk("rst_tick", 32'(tk[0]), 32'd0);
    chk("rst_tcnt", 32'(tcnt0), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_ready_b", 32'(cr[1]), 32'd0);
    chk("rst_cs_b", 32'(cs[1]), 32'd0);
    step();
    reset = 1'b0;
    r = cyc;

    repeat (8) step();
    model_start(2'd0, 32'd50000);
    check_log("auto", 1, r);
    @(negedge clk);
    chk("auto_ready", 32'(cr[1]), 32'd1);

    bsy_cnt[0] = 0;
    send(0, 2'd0, 32'h0001_86A0, acc);
    ticks_a = 0;
    repeat (8) step();
    model_start(2'd0, 32'h0001_86A0);
    check_log("start_cont", 0, acc + 1);
    chk("start_busy", 32'(bsy_cnt[0]), 32'd4);
    chk("start_tcnt", 32'(tcnt0), 32'(ticks_a));

    for (int i = 0; i < 3; i++) begin
      op  = 2'($urandom_range(0, 1));
      per = $urandom;
      send(0, op, per, acc);
      repeat (8) step();
      model_start(op, per);
      check_log($sformatf("rand_start%0d", i), 0, acc + 1);
    end

    tk_cnt[0] = 0;
    for (int i = 0; i < 3; i++) begin
      pulse(0);
      ticks_a++;
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(wr(3'd0, 16'h0));
    check_log("irq_clr", 0, -1);
    chk("irq_ticks", 32'(tk_cnt[0]), 32'd3);
    chk("irq_tcnt", 32'(tcnt0), 32'(ticks_a));

    for (int i = 0; i < 3; i++) begin
      snap_src[0] = (i == 0) ? 32'h1234_5678 : $urandom;
      sv_cnt[0] = 0;
      send(0, 2'd3, 32'h0, acc);
      repeat (8) step();
      exp_q.push_back(wr(3'd4, 16'h0));
      exp_q.push_back(rdx(3'd4));
      exp_q.push_back(rdx(3'd5));
      check_log($sformatf("snap%0d", i), 0, acc + 1);
      chk("snap_cycle", 32'(sv_cyc[0]), 32'(acc + 5));
      chk("snap_pulses", 32'(sv_cnt[0]), 32'd1);
      chk("snap_value", sval[0], snap_src[0]);
    end

    tk_cnt[0] = 0;
    step();
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    cv[0] = 1'b1;
    cop[0] = 2'd2;
    cper[0] = 32'h0;
    @(negedge clk);
    chk("stop_ready_irq", 32'(cr[0]), 32'd0);
    wait_accept(0, acc);
    ticks_a++;
    repeat (6) step();
    exp_q.push_back(wr(3'd0, 16'h0));
    exp_q.push_back(wr(3'd1, 16'h0008));
    exp_q.push_back(wr(3'd0, 16'h0));
    check_log("stop", 0, -1);
    chk("stop_ticks", 32'(tk_cnt[0]), 32'd1);
    chk("stop_tcnt", 32'(tcnt0), 32'(ticks_a));

    send(0, 2'd1, 32'h0, acc);
    ticks_a = 0;
    repeat (8) step();
    model_start(2'd1, 32'h0);
    check_log("oneshot0", 0, acc + 1);
    chk("oneshot_tcnt", 32'(tcnt0), 32'(ticks_a));

    tk_cnt[1] = 0;
    lg1.delete();
    for (int i = 0; i < 17; i++) pulse(1);
    chk("wrap_ticks", 32'(tk_cnt[1]), 32'd17);
    chk("wrap_tcnt", 32'(tcnt1), 32'(17 % 16));

    per = $urandom | 32'h1;
    send(0, 2'd0, per, acc);
    step();
    chk("ph_cs", 32'(cs[0]), 32'd1);
    chk("ph_addr", 32'(addr[0]), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_cyc", 32'(cyc), 32'(acc + 3));
    chk("mid_rst_cs", 32'(cs[0]), 32'd0);
    chk("mid_rst_busy", 32'(bsy[0]), 32'd0);
    chk("mid_rst_tcnt", 32'(tcnt0), 32'd0);
    chk("mid_rst_tcnt_b", 32'(tcnt1), 32'd0);
    exp_q.push_back(wr(3'd2, per[15:0]));
    check_log("mid_rst", 0, acc + 1);

    repeat (8) step();
    chk("ready_vs_irq", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_bus_sequencer.md
Name: timer_bus_sequencer

Overview:
- Avalon-MM master that drives a 16-bit-data, 3-bit-word-address interval-timer slave, point-to-point with no fabric.
- Slave register map: 0 = status (write clears timeout), 1 = control {stop, start, cont, ito}, 2/3 = period lo/hi, 4/5 = snap lo/hi (write latches, read returns).
- Turns simple user commands (start continuous, start one-shot, stop, snapshot) into bus write/read sequences.
- Services the timer IRQ in hardware and counts ticks, so software or other logic never touches the timer registers.

Parameters:
- TICK_W, 16, width of tick_count.
- AUTO_START, 0, if 1, run START_CONT with DEFAULT_PERIOD after reset, before accepting commands.
- DEFAULT_PERIOD, 50000, 32-bit period used by AUTO_START.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept
- cmd_op  in  2  0=START_CONT, 1=START_ONESHOT, 2=STOP, 3=SNAPSHOT
- cmd_period  in  32  period for START ops
- snap_valid  out  1  one-cycle pulse, snap_value valid
- snap_value  out  32  captured counter snapshot
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_W  serviced timeouts since last START
- busy  out  1  state != IDLE
- tmr_address  out  3  slave word address
- tmr_chipselect  out  1  slave select
- tmr_write_n  out  1  0 = write
- tmr_writedata  out  16  write data
- tmr_readdata  in  16  slave data, registered, valid 1 cycle after address
- tmr_irq  in  1  level IRQ from slave

Behaviour:
- Clock and reset: one clock, synchronous active-high reset. Reset applies on the next edge from any state, including mid-sequence.
- Reset values: state=IDLE (or WR_PL when AUTO_START=1); chipselect=0; write_n=1; address=0; writedata=0; snap_valid=0; snap_value=0; tick=0; tick_count=0; cmd_ready=0 during reset.
- Bus outputs are registered state decodes. Every access is exactly one cycle with chipselect=1. Idle bus: chipselect=0, write_n=1, address=0, writedata=0.
- Read timing: a read presented in cycle N has its data sampled from tmr_readdata at the edge ending cycle N+1.
- cmd_ready = (state==IDLE) && !tmr_irq. Accept on cmd_valid && cmd_ready; latch cmd_op and cmd_period.
- IRQ priority: in IDLE, tmr_irq=1 takes priority over a pending cmd_valid.
- START_CONT: WR_PL (addr2, period[15:0]) -> WR_PH (addr3, period[31:16]) -> WR_ST (addr0, 0) -> WR_CTL (addr1, 0x0007) -> IDLE. tick_count cleared on acceptance.
- START_ONESHOT: same sequence, but WR_CTL writes 0x0005.
- cmd_period==0 on a START op is clamped to 1.
- STOP: STOP_CTL (addr1, 0x0008) -> STOP_ST (addr0, 0) -> IDLE. An IRQ already pending is cleared by STOP_ST and is not counted as a tick.
- SNAPSHOT: SNAP_W (addr4, write 0) -> SNAP_RL (read addr4) -> SNAP_RH (read addr5; capture lo) -> SNAP_CAP (bus idle; capture hi) -> IDLE. snap_value={hi,lo} and snap_valid=1 in the first IDLE cycle. Latency: acceptance in cycle a gives snap_valid in cycle a+5.
- IRQ service: IDLE with tmr_irq=1 -> IRQ_CLR (addr0, write 0; tick=1 this cycle; tick_count+1, wraps modulo 2^TICK_W) -> IDLE.
- IRQ re-evaluation: the slave deasserts irq the cycle after the clear, so IDLE re-evaluates correctly with no gap state.
- Lost ticks: a timeout coinciding with the clear write is lost (the slave gives the clear priority). This is accepted and documented.
- Commands arriving while busy are held by the requester (valid/ready). There is no queue.
- snap_value holds until the next snapshot. tick_count holds across STOP.

Test Plan:
- Reset, AUTO_START=0, cmd START_CONT period 0x0001_86A0 -> bus writes in 4 consecutive cycles: (2,0x86A0), (3,0x0001), (0,0x0000), (1,0x0007); busy high for exactly 4 cycles; tick_count=0.
- Slave model raises irq 3 times -> 3 IRQ_CLR writes (addr0), 3 tick pulses, tick_count=3; cmd_ready low while irq is high.
- Counter snapshot model returns 0x1234_5678 -> SNAPSHOT gives write addr4, reads addr4 then addr5; snap_value=0x12345678 with snap_valid in cycle a+5.
- STOP issued while irq is high and cmd_valid is waiting -> IRQ_CLR first (tick_count+1), then (1,0x0008), (0,0x0000).
- START_ONESHOT period 0 -> writes (2,0x0001), (3,0x0000), (0,0), (1,0x0005).
- TICK_W=4: 17 IRQs -> tick_count wraps to 1. Reset asserted during WR_PH -> next cycle chipselect=0, busy=0, tick_count=0.
- AUTO_START=1 -> after reset the START_CONT sequence runs with 50000 (0xC350, 0x0000), then cmd_ready rises.
